// File: rtl/img_pkg.sv
// Shared image-pipeline definitions.
//   PIXEL_W        default grey pixel width
//   TAP_00..TAP_22 flat index of tap (row i, col j) in a 3x3 window, k = 3*i + j
//   clog2()        ceiling log2, used to size row/column counters and RAM addresses
package img_pkg;

   localparam int unsigned PIXEL_W = 8;

   localparam int unsigned TAP_00 = 0;
   localparam int unsigned TAP_01 = 1;
   localparam int unsigned TAP_02 = 2;
   localparam int unsigned TAP_10 = 3;
   localparam int unsigned TAP_11 = 4;
   localparam int unsigned TAP_12 = 5;
   localparam int unsigned TAP_20 = 6;
   localparam int unsigned TAP_21 = 7;
   localparam int unsigned TAP_22 = 8;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
//   pixel_valid, pixel_in   raster-order pixel stream into the generator
//   win_valid               one-cycle pulse per emitted window
//   win_out                 9 taps, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   win_col, win_row        position of the bottom-right tap
//   win_sof, win_eof        first / last window of a frame
// master: pixel source and window sink; slave: the generator.
interface window_3x3_gen_if
   import img_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = PIXEL_W,
   parameter int unsigned IMAGE_WIDTH  = 320,
   parameter int unsigned IMAGE_HEIGHT = 464
);

   localparam int unsigned COL_W = clog2(IMAGE_WIDTH);
   localparam int unsigned ROW_W = clog2(IMAGE_HEIGHT);

   logic                    pixel_valid;
   logic [DATA_WIDTH-1:0]   pixel_in;
   logic                    win_valid;
   logic [9*DATA_WIDTH-1:0] win_out;
   logic [COL_W-1:0]        win_col;
   logic [ROW_W-1:0]        win_row;
   logic                    win_sof;
   logic                    win_eof;

   modport master (
      output pixel_valid, pixel_in,
      input  win_valid, win_out, win_col, win_row, win_sof, win_eof
   );

   modport slave (
      input  pixel_valid, pixel_in,
      output win_valid, win_out, win_col, win_row, win_sof, win_eof
   );

endinterface

// File: rtl/line_ram.sv
// Simple dual-port line buffer, read-first, one-cycle registered read.
//   clk          clock
//   we/waddr/wdata  write port
//   re/raddr     read port; rdata updates only when re is high
//   rdata        registered read data (old contents on a same-address write)
// Contents are not reset; the window generator masks stale rows.
module line_ram
   import img_pkg::*;
#(
   parameter int unsigned DEPTH  = 320,
   parameter int unsigned WIDTH  = PIXEL_W,
   parameter int unsigned ADDR_W = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem_q[raddr];
      end
   end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming causal 3x3 neighbourhood generator.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         window_3x3_gen_if slave: pixel stream in, one window out per pixel,
//               fixed two-cycle latency, out-of-frame taps replaced by BORDER_VAL.
// Two line RAMs hold rows r-1 (mid) and r-2 (top); rows are rotated by writing the
// pixel into mid and the old mid value into top at the same column.
module window_3x3_gen
   import img_pkg::*;
#(
   parameter int unsigned           IMAGE_WIDTH  = 320,
   parameter int unsigned           IMAGE_HEIGHT = 464,
   parameter int unsigned           DATA_WIDTH   = PIXEL_W,
   parameter logic [DATA_WIDTH-1:0] BORDER_VAL   = '0
) (
   input logic             clk,
   input logic             rst_n,
   window_3x3_gen_if.slave bus
);

   localparam int unsigned      COL_W    = clog2(IMAGE_WIDTH);
   localparam int unsigned      ROW_W    = clog2(IMAGE_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

   // Stage 0: position counters
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             col_last, row_last;

   // Stage 1: pixel and position aligned with the RAM read data
   logic                  s1_valid_q, s1_sof_q, s1_eof_q;
   logic [DATA_WIDTH-1:0] s1_pix_q;
   logic [COL_W-1:0]      s1_col_q;
   logic [ROW_W-1:0]      s1_row_q;
   logic [DATA_WIDTH-1:0] top_rd, mid_rd;

   // Stage 2: raw taps and registered outputs
   logic [DATA_WIDTH-1:0]   tap_q [9];
   logic [DATA_WIDTH-1:0]   tap_d [9];
   logic [2:0]              row_keep, col_keep;
   logic [9*DATA_WIDTH-1:0] win_d, win_out_q;
   logic                    win_valid_q, win_sof_q, win_eof_q;
   logic [COL_W-1:0]        win_col_q;
   logic [ROW_W-1:0]        win_row_q;

   assign col_last = (col_q == COL_LAST);
   assign row_last = (row_q == ROW_LAST);

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (bus.pixel_valid) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   line_ram #(
      .DEPTH (IMAGE_WIDTH),
      .WIDTH (DATA_WIDTH)
   ) u_mid_ram (
      .clk   (clk),
      .we    (bus.pixel_valid),
      .waddr (col_q),
      .wdata (bus.pixel_in),
      .re    (bus.pixel_valid),
      .raddr (col_q),
      .rdata (mid_rd)
   );

   // The old mid value only appears on the registered read port a cycle later, so the top
   // write trails by one cycle. The next read of that column is a full row away.
   line_ram #(
      .DEPTH (IMAGE_WIDTH),
      .WIDTH (DATA_WIDTH)
   ) u_top_ram (
      .clk   (clk),
      .we    (s1_valid_q),
      .waddr (s1_col_q),
      .wdata (mid_rd),
      .re    (bus.pixel_valid),
      .raddr (col_q),
      .rdata (top_rd)
   );

   // Shift taps one column left and load {top, mid, pixel} as the new right column.
   always_comb begin
      tap_d = tap_q;
      for (int i = 0; i < 3; i++) begin
         tap_d[3*i]     = tap_q[3*i + 1];
         tap_d[3*i + 1] = tap_q[3*i + 2];
      end
      tap_d[TAP_02] = top_rd;
      tap_d[TAP_12] = mid_rd;
      tap_d[TAP_22] = s1_pix_q;
   end

   // keep[k] clear means that tap row/column lies above or left of the frame.
   assign row_keep = {1'b1, (s1_row_q != '0), (s1_row_q > ROW_W'(1))};
   assign col_keep = {1'b1, (s1_col_q != '0), (s1_col_q > COL_W'(1))};

   always_comb begin
      win_d = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            win_d[(3*i + j)*DATA_WIDTH +: DATA_WIDTH] =
               (row_keep[i] && col_keep[j]) ? tap_d[3*i + j] : BORDER_VAL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_eof_q    <= 1'b0;
         s1_pix_q    <= '0;
         s1_col_q    <= '0;
         s1_row_q    <= '0;
         tap_q       <= '{default: '0};
         win_out_q   <= '0;
         win_valid_q <= 1'b0;
         win_sof_q   <= 1'b0;
         win_eof_q   <= 1'b0;
         win_col_q   <= '0;
         win_row_q   <= '0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         s1_valid_q <= bus.pixel_valid;
         if (bus.pixel_valid) begin
            s1_pix_q <= bus.pixel_in;
            s1_col_q <= col_q;
            s1_row_q <= row_q;
            s1_sof_q <= (col_q == '0) && (row_q == '0);
            s1_eof_q <= col_last && row_last;
         end
         win_valid_q <= s1_valid_q;
         win_sof_q   <= s1_valid_q && s1_sof_q;
         win_eof_q   <= s1_valid_q && s1_eof_q;
         if (s1_valid_q) begin
            tap_q     <= tap_d;
            win_out_q <= win_d;
            win_col_q <= s1_col_q;
            win_row_q <= s1_row_q;
         end
      end
   end

   assign bus.win_valid = win_valid_q;
   assign bus.win_out   = win_out_q;
   assign bus.win_col   = win_col_q;
   assign bus.win_row   = win_row_q;
   assign bus.win_sof   = win_sof_q;
   assign bus.win_eof   = win_eof_q;

endmodule
